// File: rtl/bcau_sched_pkg.sv
// Shared types and constants for the BCAU scheduler.
package bcau_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'b00,
    BUSY  = 2'b01,
    DRAIN = 2'b10
  } sched_state_t;

  localparam int BCAU_PIX_BEATS = 81;
  // Cycles from the issue cycle to the first result valid.
  localparam int BCAU_NOM_LAT   = 162;

endpackage

// File: rtl/bcau_sched_if.sv
// Scheduler-side bundle: IRU request/grant, BCAU handshake, HEU result fan-out, status.
interface bcau_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic               bcau_go;
  logic               bcau_ready;
  logic               bcau_valid;
  logic               bcau_ack;
  logic [ID_W-1:0]    in_sel;
  logic [ID_W-1:0]    owner_id;
  logic [NUM_REQ-1:0] heu_valid;
  logic [NUM_REQ-1:0] heu_ready;
  logic               busy;
  logic [CNT_W-1:0]   job_count;
  logic               proto_err;
  logic               timeout_err;

  // master: the scheduler itself
  modport master (
    input  req_valid, bcau_ready, bcau_valid, heu_ready,
    output req_ready, bcau_go, bcau_ack, in_sel, owner_id, heu_valid,
           busy, job_count, proto_err, timeout_err
  );

  // slave: the surrounding IRU/BCAU/HEU environment
  modport slave (
    output req_valid, bcau_ready, bcau_valid, heu_ready,
    input  req_ready, bcau_go, bcau_ack, in_sel, owner_id, heu_valid,
           busy, job_count, proto_err, timeout_err
  );
endinterface

// File: rtl/bcau_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request scanning up from i_ptr, with wrap.
module rr_arbiter
  import bcau_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  // Scan from the farthest offset back to i_ptr so the nearest hit wins.
  always_comb begin
    logic [ID_W-1:0] k;
    k     = '0;
    o_any = 1'b0;
    o_idx = '0;
    o_gnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = ID_W'((int'(i_ptr) + i) % NUM_REQ);
      if (i_req[k]) begin
        o_any = 1'b1;
        o_idx = k;
      end
    end
    o_gnt[o_idx] = o_any;
  end

endmodule

// File: rtl/bcau_sched.sv
// Shares one BCAU among NUM_REQ IRU lanes: round-robin issue, result routing to the
// owning HEU lane, and sticky protocol/hang monitoring.
module bcau_sched
  import bcau_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = 200,
  parameter int CNT_W   = 16
) (
  input logic          clk,
  input logic          rst,
  bcau_sched_if.master bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  sched_state_t       r_state, w_next;
  logic [ID_W-1:0]    r_rr_ptr, r_owner, w_win;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_any;
  logic [WD_W-1:0]    r_wd;
  logic [CNT_W-1:0]   r_jobs;
  logic               r_proto, r_tmo;
  logic               w_own_rdy, w_done;
  logic [NUM_REQ-1:0] w_req_ready, w_heu_valid;
  logic               w_go, w_ack;
  logic [ID_W-1:0]    w_in_sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .i_req (bus.req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_win),
    .o_any (w_any)
  );

  assign w_own_rdy = bus.heu_ready[r_owner];
  assign w_done    = bus.bcau_valid && w_own_rdy;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ARB;
    else     r_state <= w_next;
  end

  // Next state: a valid drop in DRAIN returns to ARB just like a completion.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB:     if (w_any) w_next = BUSY;
      BUSY:    if (bus.bcau_valid) w_next = DRAIN;
      DRAIN:   if (w_done || !bus.bcau_valid) w_next = ARB;
      default: w_next = ARB;
    endcase
  end

  // Handshake outputs; bcau_go never looks at bcau_ready so no loop forms through BCAU.
  always_comb begin
    w_req_ready = '0;
    w_heu_valid = '0;
    w_go        = 1'b0;
    w_ack       = 1'b0;
    w_in_sel    = '0;
    if (!rst) begin
      case (r_state)
        ARB: begin
          w_go        = w_any;
          w_req_ready = w_gnt;
          w_in_sel    = w_win;
        end
        DRAIN: begin
          w_heu_valid[r_owner] = bus.bcau_valid;
          w_ack                = w_own_rdy;
        end
        default: ;
      endcase
    end
  end

  // Job bookkeeping, watchdog and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_wd     <= '0;
      r_jobs   <= '0;
      r_proto  <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      case (r_state)
        ARB: begin
          if (w_any) begin
            r_owner  <= w_win;
            r_rr_ptr <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
            r_wd     <= '0;
          end else if (!bus.bcau_ready) begin
            r_proto <= 1'b1;
          end
        end
        BUSY: begin
          if (r_wd != WD_W'(TIMEOUT)) r_wd <= r_wd + 1'b1;
          // Raised on the same edge that saturates wd_cnt, i.e. TIMEOUT
          // busy cycles passed with no result.
          if (!bus.bcau_valid && r_wd == WD_W'(TIMEOUT - 1)) r_tmo <= 1'b1;
        end
        DRAIN: begin
          if (w_done)                r_jobs  <= r_jobs + 1'b1;
          else if (!bus.bcau_valid)  r_proto <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.bcau_go     = w_go;
  assign bus.bcau_ack    = w_ack;
  assign bus.in_sel      = w_in_sel;
  assign bus.owner_id    = r_owner;
  assign bus.heu_valid   = w_heu_valid;
  assign bus.busy        = (r_state != ARB);
  assign bus.job_count   = r_jobs;
  assign bus.proto_err   = r_proto;
  assign bus.timeout_err = r_tmo;

endmodule

// File: doc/bcau_sched.md
Name: bcau_sched

Overview:
- Scheduler that shares one BCAU datapath among NUM_REQ upstream IRU lanes and routes each result to the matching downstream HEU lane.
- Round-robin grant per job.
- Drives the BCAU start/ack handshake and the lane select for the input mux and output demux.
- Monitors BCAU for protocol errors and hangs.

Parameters:
- NUM_REQ, 4: number of IRU/HEU lane pairs (2..8).
- ID_W, $clog2(NUM_REQ): lane index width.
- TIMEOUT, 200: maximum cycles from issue to first bcau_valid before timeout_err is raised (nominal BCAU latency is 162).
- CNT_W, 16: job counter width.

Ports:
- clk  in  1  clock; the block's only clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_REQ  per-lane IRU valid; level, held until req_ready.
- req_ready  out  NUM_REQ  one-hot grant/accept pulse to the winning lane.
- bcau_go  out  1  drives BCAU iru_valid.
- bcau_ready  in  1  BCAU ready; used for checking only.
- bcau_valid  in  1  BCAU result valid.
- bcau_ack  out  1  drives BCAU heu_ready.
- in_sel  out  ID_W  lane select for the BCAU input mux; valid while bcau_go=1.
- owner_id  out  ID_W  lane owning the in-flight job; selects the output demux.
- heu_valid  out  NUM_REQ  per-lane result valid.
- heu_ready  in  NUM_REQ  per-lane HEU ready.
- busy  out  1  job in flight (state != ARB).
- job_count  out  CNT_W  completed jobs; wraps.
- proto_err  out  1  sticky; cleared only by rst.
- timeout_err  out  1  sticky; cleared only by rst.

Behaviour:
- Reset (rst=1 at posedge): state=ARB, rr_ptr=0, owner_id=0, wd_cnt=0, job_count=0, proto_err=0, timeout_err=0.
- While rst=1, all combinational outputs are forced to 0: req_ready, bcau_go, bcau_ack, heu_valid.
- Reset mid-job abandons the job. BCAU is reset by the same system reset; no drain is attempted.
- States: ARB, BUSY, DRAIN.
- ARB:
  - bcau_go = |req_valid. It is computed only from registered state and req_valid, never from bcau_ready, to avoid a combinational loop with BCAU.
  - The winner is the first asserted lane scanning from rr_ptr upward, with modulo-NUM_REQ wrap.
  - In the issue cycle: req_ready[winner]=1, in_sel=winner.
  - Next edge: owner_id<=winner, rr_ptr<=(winner+1)%NUM_REQ, wd_cnt<=0, state<=BUSY.
  - No request: stay in ARB; rr_ptr is unchanged.
  - If bcau_ready=0 in an ARB cycle with no issue, set proto_err.
- BUSY:
  - wd_cnt increments each cycle, saturating at TIMEOUT.
  - If wd_cnt reaches TIMEOUT, set timeout_err and remain in BUSY.
  - The first cycle with bcau_valid=1 moves the state to DRAIN at the next edge. heu_valid stays 0 during BUSY, which absorbs the BCAU exit-cycle valid pulse.
- DRAIN:
  - heu_valid[owner_id] = bcau_valid.
  - bcau_ack = heu_ready[owner_id].
  - Completion is bcau_valid && heu_ready[owner_id]: job_count++ and state<=ARB.
  - If bcau_valid drops in DRAIN without completion, set proto_err and return to ARB.
- Latency: the issue cycle is t. The first bcau_valid arrives at t+162 and DRAIN is entered at t+163. If HEU is ready, completion is at t+163 and the next issue is possible at t+164. Minimum spacing between issues is therefore 164 cycles.
- Simultaneous events:
  - A request from the owner lane during BUSY/DRAIN waits for ARB; it does not get the grant repeatedly because rr_ptr has advanced.
  - A lane dropping req_valid before grant is simply not considered.
  - Other lanes' heu_ready values are ignored.
- req_ready is never asserted outside ARB. At most one bit of req_ready or heu_valid is set in any cycle.
- job_count wraps from 2^CNT_W-1 to 0.

Decomposition:
- Shared package bcau_pkg:
  - sched_state_t enum: ARB=2'b00, BUSY=2'b01, DRAIN=2'b10.
  - BCAU_PIX_BEATS=81.
  - BCAU_NOM_LAT=162.
- Sub-module rr_arbiter: purely combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, winner index, any.
  - rr_ptr stays registered in bcau_sched.

Test Plan:
- Single lane: req_valid=4'b0100 at t → req_ready=4'b0100, bcau_go=1, in_sel=2 at t. BCAU model valid at t+162, heu_ready[2]=1 → heu_valid=4'b0100 at t+163, job_count=1, busy=0 at t+164.
- All four lanes held valid → grants in order 0,1,2,3,0, each 164 cycles apart. No grant while busy=1.
- Backpressure: lane 1 owns the job, heu_ready[1]=0 for 50 cycles with heu_ready[0]=1 → heu_valid[1] and bcau_valid held; bcau_ack=0. Completion on the first heu_ready[1]=1.
- Hung BCAU (no bcau_valid) → timeout_err=1 exactly 200 cycles after issue; state stays BUSY; proto_err=0.
- Protocol error: bcau_ready=0 while in ARB with no request → proto_err=1 next cycle and stays sticky. Separately, bcau_valid drop in DRAIN → proto_err=1, state returns to ARB.
- rst=1 at t+80 of a job → all outputs 0 and rr_ptr=0. A new request on lane 3 after rst drops is granted in the first ARB cycle.
